// File: rtl/dma_seq_pkg.sv
// Shared defaults and helpers for the round-robin DMA sequencer.
// Optional high-priority class is enabled with DMA_SEQ_PRIO_EN.
package dma_seq_pkg;

   localparam int DEVNUM_DEF = 4;
   localparam int AW_DEF     = 22;
   localparam int DW_DEF     = 8;
   localparam int BCNT_W     = 8;

   // Index width for a one-hot vector of v entries, never less than 1.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: fixed priority from index 0 when prev is zero,
// otherwise rotating upward from prev+1 with prev itself considered last.
module rr_pick
   import dma_seq_pkg::*;
#(
   parameter int N = DEVNUM_DEF
) (
   input  logic [N-1:0] reqs,
   input  logic [N-1:0] prev,
   output logic [N-1:0] next
);

   localparam int IW = clog2(N);

   logic [IW-1:0] p;
   logic          found;
   int            j;

   always_comb begin
      next  = '0;
      found = 1'b0;
      p     = '0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         if (prev[i]) p = IW'(i);
      end
      if (prev == '0) begin
         for (int i = 0; i < N; i++) begin
            if (reqs[i] && !found) begin
               next[i] = 1'b1;
               found   = 1'b1;
            end
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            j = (int'(p) + k) % N;
            if (reqs[j] && !found) begin
               next[j] = 1'b1;
               found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dma_seq_rr.sv
// N-channel DMA sequencer: round-robin grants with a per-grant burst allowance,
// muxing channel requests onto one controller port. Option: DMA_SEQ_PRIO_EN.
module dma_seq_rr
   import dma_seq_pkg::*;
#(
   parameter int DEVNUM = DEVNUM_DEF,
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int BURST  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef DMA_SEQ_PRIO_EN
   input  logic [DEVNUM-1:0]    prio,
`endif
   input  logic [DEVNUM-1:0]    reqs,
   input  logic [DEVNUM*AW-1:0] addrs,
   input  logic [DEVNUM-1:0]    rnws,
   input  logic [DEVNUM*DW-1:0] wds,
   output logic [DEVNUM-1:0]    acks,
   output logic [DEVNUM-1:0]    ends,
   output logic                 dma_req,
   output logic [AW-1:0]        dma_addr,
   output logic                 dma_rnw,
   output logic [DW-1:0]        dma_wd,
   input  logic                 dma_ack,
   input  logic                 dma_end
);

   localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(BURST - 1);

   logic                busy;
   logic [DEVNUM-1:0]   grant;
   logic [DEVNUM-1:0]   owner;
   logic [BCNT_W-1:0]   bcnt;
   logic [DEVNUM-1:0]   pick;
   logic                arb_ev;
   logic                keep;
   logic                rnw_sel;

`ifdef DMA_SEQ_PRIO_EN
   logic [DEVNUM-1:0] req_hi, req_lo, pick_hi, pick_lo;

   assign req_hi = reqs & prio;
   assign req_lo = reqs & ~prio;

   rr_pick #(.N(DEVNUM)) u_pick_hi (.reqs(req_hi), .prev(grant), .next(pick_hi));
   rr_pick #(.N(DEVNUM)) u_pick_lo (.reqs(req_lo), .prev(grant), .next(pick_lo));

   assign pick = (|req_hi) ? pick_hi : pick_lo;
`else
   rr_pick #(.N(DEVNUM)) u_pick (.reqs(reqs), .prev(grant), .next(pick));
`endif

   assign arb_ev = !busy || dma_ack;
   // bcnt never passes BMAX, so inequality is the same as "below the limit".
   assign keep   = (|(grant & reqs)) && (bcnt != BMAX);

   always_comb begin
      dma_addr = '0;
      dma_wd   = '0;
      rnw_sel  = 1'b0;
      for (int i = 0; i < DEVNUM; i++) begin
         dma_addr = dma_addr | (addrs[i*AW +: AW] & {AW{grant[i]}});
         dma_wd   = dma_wd   | (wds[i*DW +: DW]   & {DW{grant[i]}});
         rnw_sel  = rnw_sel  | (rnws[i] & grant[i]);
      end
      dma_req = |(grant & reqs);
      dma_rnw = (grant == '0) | rnw_sel;
   end

   assign acks = grant & {DEVNUM{dma_ack}};
   assign ends = owner & {DEVNUM{dma_end}};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         grant <= '0;
         owner <= '0;
         bcnt  <= '0;
      end else begin
         busy <= busy ? dma_req : (|reqs);
         if (dma_ack) owner <= grant;
         if (arb_ev) begin
            if (keep) begin
               bcnt <= bcnt + BCNT_W'(1);
            end else begin
               grant <= pick;
               bcnt  <= '0;
            end
         end else if (busy && !dma_req) begin
            // Grantee abandoned its request: go idle so the next pick is a fresh idle start.
            grant <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dma_seq_rr.sv
// Bench for dma_seq_rr: one instance with BURST=1 and one with BURST=3 share
// channel stimulus; each has its own controller handshake and scoreboard.
module tb_dma_seq_rr;

   localparam int N  = 4;
   localparam int AW = 22;
   localparam int DW = 8;
   localparam int W  = N + AW + 1 + DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [N-1:0]    reqs;
   logic [N-1:0]    rnws;
   logic [N*AW-1:0] addrs;
   logic [N*DW-1:0] wds;
`ifdef DMA_SEQ_PRIO_EN
   logic [N-1:0]    prio = '0;
`endif

   logic            ack1, end1, ack3, end3;
   logic [N-1:0]    acks1, ends1, acks3, ends3;
   logic            dma_req1, dma_rnw1, dma_req3, dma_rnw3;
   logic [AW-1:0]   dma_addr1, dma_addr3;
   logic [DW-1:0]   dma_wd1, dma_wd3;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q1[$];
   logic [W-1:0] exp_q3[$];
   logic [N-1:0] end_q1[$];

   dma_seq_rr #(.DEVNUM(N), .AW(AW), .DW(DW), .BURST(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
`ifdef DMA_SEQ_PRIO_EN
      .prio(prio),
`endif
      .reqs(reqs), .addrs(addrs), .rnws(rnws), .wds(wds),
      .acks(acks1), .ends(ends1),
      .dma_req(dma_req1), .dma_addr(dma_addr1), .dma_rnw(dma_rnw1), .dma_wd(dma_wd1),
      .dma_ack(ack1), .dma_end(end1)
   );

   dma_seq_rr #(.DEVNUM(N), .AW(AW), .DW(DW), .BURST(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
`ifdef DMA_SEQ_PRIO_EN
      .prio(prio),
`endif
      .reqs(reqs), .addrs(addrs), .rnws(rnws), .wds(wds),
      .acks(acks3), .ends(ends3),
      .dma_req(dma_req3), .dma_addr(dma_addr3), .dma_rnw(dma_rnw3), .dma_wd(dma_wd3),
      .dma_ack(ack3), .dma_end(end3)
   );

   function automatic logic [AW-1:0] addr_of(input int ch);
      return AW'(22'h3A000 + 22'h111 * ch);
   endfunction

   function automatic logic [DW-1:0] wd_of(input int ch);
      return DW'(8'hA0 + ch);
   endfunction

   function automatic logic [W-1:0] exp_ack(input int ch);
      logic [N-1:0] oh;
      oh     = '0;
      oh[ch] = 1'b1;
      return {oh, addr_of(ch), rnws[ch], wd_of(ch)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Controller model: wait (bounded) for a request, then ack two cycles later.
   task automatic ack_pulse(input int which, input logic with_end);
      int t;
      t = 0;
      while (((which == 1) ? dma_req1 : dma_req3) !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      check("ack_wait_req", (which == 1) ? dma_req1 : dma_req3, 1);
      repeat (2) tick();
      if (which == 1) begin
         ack1 = 1'b1;
         end1 = with_end;
      end else begin
         ack3 = 1'b1;
         end3 = with_end;
      end
      tick();
      ack1 = 1'b0;
      end1 = 1'b0;
      ack3 = 1'b0;
      end3 = 1'b0;
   endtask

   // Monitors: compare whatever the DUTs present against the expected queues.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (acks1 != '0) begin
            if (exp_q1.size() == 0) check("ack1_unexpected", acks1, 0);
            else check("ack1", {acks1, dma_addr1, dma_rnw1, dma_wd1}, exp_q1.pop_front());
         end
         if (acks3 != '0) begin
            if (exp_q3.size() == 0) check("ack3_unexpected", acks3, 0);
            else check("ack3", {acks3, dma_addr3, dma_rnw3, dma_wd3}, exp_q3.pop_front());
         end
         if (ends1 != '0) begin
            if (end_q1.size() == 0) check("end1_unexpected", ends1, 0);
            else check("end1", ends1, end_q1.pop_front());
         end
         if (ends3 != '0) check("end3_unexpected", ends3, 0);
      end
   end

   initial begin
      rst_n = 1'b0;
      ack1  = 1'b0;
      end1  = 1'b0;
      ack3  = 1'b0;
      end3  = 1'b0;
      rnws  = 4'b0101;
      reqs  = 4'b1111;
      addrs = '0;
      wds   = '0;
      for (int ch = 0; ch < N; ch++) begin
         addrs[ch*AW +: AW] = addr_of(ch);
         wds[ch*DW +: DW]   = wd_of(ch);
      end

      // Reset held with all channels requesting.
      repeat (3) tick();
      check("rst_req1", dma_req1, 0);
      check("rst_rnw1", dma_rnw1, 1);
      check("rst_addr1", dma_addr1, 0);
      check("rst_wd1", dma_wd1, 0);
      check("rst_req3", dma_req3, 0);

      rst_n = 1'b1;
      #1;
      check("rel_req1", dma_req1, 0);
      tick();
      check("first_req1", dma_req1, 1);
      check("first_addr1", dma_addr1, addr_of(0));
      check("first_rnw1", dma_rnw1, 1);
      check("first_wd1", dma_wd1, wd_of(0));
      check("first_req3", dma_req3, 1);

      // Pure rotation on the BURST=1 instance.
      reqs = 4'b1011;
      exp_q1.push_back(exp_ack(0));
      exp_q1.push_back(exp_ack(1));
      exp_q1.push_back(exp_ack(3));
      exp_q1.push_back(exp_ack(0));
      exp_q1.push_back(exp_ack(1));
      exp_q1.push_back(exp_ack(3));
      for (int i = 0; i < 6; i++) ack_pulse(1, 1'b0);

      // Burst limit on the BURST=3 instance.
      reqs = 4'b0101;
      exp_q3.push_back(exp_ack(0));
      exp_q3.push_back(exp_ack(0));
      exp_q3.push_back(exp_ack(0));
      exp_q3.push_back(exp_ack(2));
      exp_q3.push_back(exp_ack(2));
      exp_q3.push_back(exp_ack(2));
      exp_q3.push_back(exp_ack(0));
      for (int i = 0; i < 7; i++) ack_pulse(3, 1'b0);

      // Grantee drops its request before ack.
      reqs = 4'b0100;
      #1;
      check("drop_req_comb", dma_req3, 0);
      tick();
      check("drop_idle_gap", dma_req3, 0);
      tick();
      check("drop_regrant_req", dma_req3, 1);
      check("drop_regrant_addr", dma_addr3, addr_of(2));

      // End routing across a same-cycle ack/end.
      reqs = 4'b0010;
      repeat (3) tick();
      reqs = 4'b0110;
      exp_q1.push_back(exp_ack(1));
      exp_q1.push_back(exp_ack(2));
      end_q1.push_back(4'b0010);
      end_q1.push_back(4'b0100);
      ack_pulse(1, 1'b0);
      ack_pulse(1, 1'b1);
      end1 = 1'b1;
      tick();
      end1 = 1'b0;

      // No requesters: datapath returns to its idle values.
      reqs = 4'b0000;
      repeat (3) tick();
      check("idle_req1", dma_req1, 0);
      check("idle_rnw1", dma_rnw1, 1);
      check("idle_addr1", dma_addr1, 0);

      repeat (5) tick();
      check("exp_q1_drained", exp_q1.size(), 0);
      check("exp_q3_drained", exp_q3.size(), 0);
      check("end_q1_drained", end_q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_seq_rr.md
# dma_seq_rr

Parametrised N-channel DMA sequencer. It sits between up to `DEVNUM` DMA end-users and the single DMA controller port. It arbitrates requests round-robin with a per-grant burst allowance. It muxes address, rnw and write data to the controller, and demuxes `ack`/`end` back to the owning channel. It generalises the fixed 4-channel, 22-bit sequencer to any channel count, any address/data width, and multi-transfer bursts.

## Interface
Parameters:
- `DEVNUM`, 4: number of requesting channels (2..16).
- `AW`, 22: DMA address width.
- `DW`, 8: DMA data width.
- `BURST`, 1: max consecutive transfers granted to one channel before rotating (1..255). 1 gives pure round-robin.

Ports:
- `clk`  in  1: the only clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `reqs`  in  DEVNUM: per-channel request.
- `addrs`  in  DEVNUM*AW: channel i occupies bits [i*AW +: AW].
- `rnws`  in  DEVNUM: per-channel read-not-write.
- `wds`  in  DEVNUM*DW: channel i occupies bits [i*DW +: DW].
- `acks`  out  DEVNUM: per-channel ack.
- `ends`  out  DEVNUM: per-channel end.
- `dma_req`  out  1, `dma_addr`  out  AW, `dma_rnw`  out  1, `dma_wd`  out  DW: to the controller.
- `dma_ack`  in  1, `dma_end`  in  1: from the controller.
- `prio`  in  DEVNUM: present only with `DMA_SEQ_PRIO_EN`; high-priority class mask.

## Operation
Registers:
- `busy`
- `grant` (one-hot or zero)
- `owner` (one-hot or zero, used for `end` routing)
- `bcnt` (8 bit)

Reset (rst_n low at a clk edge): `busy`=0, `grant`=0, `owner`=0, `bcnt`=0.

`busy` update:
- When idle: `busy` <= |reqs.
- When busy: `busy` <= `dma_req`.

Arbitration event: `!busy || dma_ack`. On each event `grant` is reloaded as follows:
- **Keep:** the current grantee still requests and `bcnt` < BURST-1. `grant` is unchanged and `bcnt` increments.
- **Rotate:** `grant` != 0 and Keep does not apply. The first requesting channel scanning upward from grantee+1, wrapping modulo DEVNUM, wins. The grantee itself is considered last. `bcnt`=0.
- **Idle start:** `grant`==0. Fixed priority applies; the lowest requesting index wins. `bcnt`=0.
- No requests: `grant`=0.

Datapath and handshake outputs (all AND-OR muxes on `grant`):
- `dma_req` = |(grant & reqs).
- `dma_addr` / `dma_wd` are the granted channel's fields, 0 when `grant`==0.
- `dma_rnw` is the granted channel's rnw, 1 when `grant`==0.
- `acks` = grant & {DEVNUM{dma_ack}}.
- `owner` <= `grant` when `dma_ack`. `ends` = owner & {DEVNUM{dma_end}}.

Boundary behaviour:
- A grantee dropping its request before `dma_ack` deasserts `dma_req` combinationally. `busy` clears next cycle, then idle-start arbitration follows.
- `dma_ack` and `dma_end` in the same cycle: `end` routes to the old `owner`, and `owner` takes the new `grant` at that edge.
- Reset mid-transfer drops `grant` and `owner` immediately at the edge; any pending `end` is lost.

## Timing
- Request rising at edge n: when idle, `grant` and `dma_req` are valid after edge n+1 (1-cycle latency).
- `acks` and `ends` are combinational from `dma_ack`/`dma_end`, with 0 added latency.
- Back-to-back transfers: the new grantee is valid in the cycle after `dma_ack`, with no idle gap.
- A channel that requests continuously gets at most BURST acks out of every BURST + (other active channels' grants).

## Configuration
`DMA_SEQ_PRIO_EN`:
- **Defined:** the `prio` port exists. At every Rotate or Idle-start decision, channels with both `reqs` and `prio` set are arbitrated first, using the same rotation/fixed rule within that class. Non-prio channels are considered only if no prio channel requests. Keep still applies regardless of class, so a granted low-priority burst finishes.
- **Undefined:** the port is absent and all channels form one class.

## Structure
- Shared package `dma_seq_pkg`: `DEVNUM`/`AW`/`DW` defaults, the `BURST` counter width (8), and a `clog2` function.
- One sub-module, `rr_pick`: combinational one-hot picker with inputs `reqs`, `prev` (one-hot or zero) and output `next`. It implements the rotate/idle-start rule. It is instantiated once, or twice (prio class and normal class) with `DMA_SEQ_PRIO_EN`.

## Test plan
1. **Reset values:** reset with DEVNUM=4 and reqs=4'b1111 → `grant`=0, `dma_req`=0, `dma_rnw`=1, `dma_addr`=0 while reset is held. First grant goes to ch0 one cycle after release.
2. **Rotation:** BURST=1, reqs=4'b1011 held, controller acking every 3 cycles → ack order 0,1,3,0,1,3. `dma_addr` tracks the granted channel's field.
3. **Burst limit:** BURST=3, ch0 and ch2 requesting continuously → ack order 0,0,0,2,2,2,0. `bcnt` resets on each switch.
4. **End routing:** `dma_ack` on ch1, then a same-cycle `dma_ack`(ch2) with `dma_end` → that end appears on `ends[1]`; the next `dma_end` appears on `ends[2]`.
5. **Dropped request:** the grantee drops `req` before ack → `dma_req` falls in the same cycle, and the other requester is granted two cycles later via idle-start.
6. **Priority (with `DMA_SEQ_PRIO_EN`):** prio=4'b1000, reqs=4'b1111 → ch3 is granted at every decision while it requests. Ch0..2 rotate only when `reqs[3]`=0.
